// File: rtl/pad_bank_filter.sv
// pad_bank_filter: N bidirectional pads with synchronised, glitch-filtered
// inputs, rise/fall event pulses and sticky per-channel interrupt status.
module pad_bank_filter #(
    parameter int                N_PADS    = 8,
    parameter int                FILT_W    = 8,
    parameter logic [N_PADS-1:0] PULL_MASK = '0,
    parameter logic [N_PADS-1:0] PULL_UP   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_PADS-1:0] pad_oen_i,
    input  logic [N_PADS-1:0] pad_out_i,
    output logic [N_PADS-1:0] pad_in_raw_o,
    output logic [N_PADS-1:0] pad_in_o,
    input  logic [N_PADS-1:0] filt_en_i,
    input  logic [FILT_W-1:0] filt_thr_i,
    output logic [N_PADS-1:0] evt_rise_o,
    output logic [N_PADS-1:0] evt_fall_o,
    input  logic [N_PADS-1:0] irq_rise_en_i,
    input  logic [N_PADS-1:0] irq_fall_en_i,
    input  logic [N_PADS-1:0] irq_clr_i,
    output logic [N_PADS-1:0] irq_status_o,
    output logic              irq_o,
    inout  wire  [N_PADS-1:0] pad_io
);

    localparam logic [FILT_W-1:0] CNT_MAX = '1;
    localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

    logic [N_PADS-1:0] sync1_q;
    logic [N_PADS-1:0] sync2_q;
    logic [N_PADS-1:0] pad_in_q;
    logic [N_PADS-1:0] pad_in_d;
    logic [FILT_W-1:0] cnt_q [N_PADS];
    logic [FILT_W-1:0] cnt_d [N_PADS];
    logic [1:0]        warm_q;
    logic [1:0]        warm_d;
    logic              warm_done;
    logic [N_PADS-1:0] rise_q;
    logic [N_PADS-1:0] rise_d;
    logic [N_PADS-1:0] fall_q;
    logic [N_PADS-1:0] fall_d;
    logic [N_PADS-1:0] status_q;
    logic [N_PADS-1:0] status_d;

    // IOBUF per pad (T=oen, I=out, O=pin) with optional static pull
    for (genvar k = 0; k < N_PADS; k++) begin : g_pad
        assign pad_io[k] = pad_oen_i[k] ? 1'bz : pad_out_i[k];
        if (PULL_MASK[k]) begin : g_pull
            if (PULL_UP[k]) begin : g_up
                pullup u_pu (pad_io[k]);
            end else begin : g_dn
                pulldown u_pd (pad_io[k]);
            end
        end
    end

    // The input path always observes the pin, so driven pads loop back.
    assign pad_in_raw_o = pad_io;

    // Two-flop synchroniser on the raw pin value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_in_raw_o;
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: accept a new level once it persisted past the threshold
    always_comb begin
        pad_in_d = pad_in_q;
        for (int k = 0; k < N_PADS; k++) begin
            cnt_d[k] = '0;
            if (!filt_en_i[k]) begin
                pad_in_d[k] = sync2_q[k];
            end else if (sync2_q[k] != pad_in_q[k]) begin
                if (cnt_q[k] >= filt_thr_i) begin
                    pad_in_d[k] = sync2_q[k];
                end else if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end else begin
                    cnt_d[k] = cnt_q[k];
                end
            end
        end
    end

    // Warm-up window hides the reset-release settling of pad_in
    assign warm_done = (warm_q == 2'd3);
    assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;

    // Edge events coincide with the filtered output taking its new value
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (warm_done) begin
            rise_d = pad_in_d & ~pad_in_q;
            fall_d = ~pad_in_d & pad_in_q;
        end
    end

    // Sticky status: a new event beats a simultaneous clear
    assign status_d = (status_q & ~irq_clr_i)
                    | (rise_q & irq_rise_en_i)
                    | (fall_q & irq_fall_en_i);

    // Filter, event and status state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_in_q <= '0;
            warm_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            for (int k = 0; k < N_PADS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            pad_in_q <= pad_in_d;
            warm_q   <= warm_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            for (int k = 0; k < N_PADS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign pad_in_o     = pad_in_q;
    assign evt_rise_o   = rise_q;
    assign evt_fall_o   = fall_q;
    assign irq_status_o = status_q;
    assign irq_o        = |status_q;

endmodule

// File: doc/pad_bank_filter.md
# pad_bank_filter

Parametrised FPGA-emulation pad bank: N bidirectional pads mapped to Xilinx IOBUF primitives, plus a clocked input path per channel. Each channel has a 2-flop synchroniser, a runtime-configurable glitch filter, rise/fall event detection and sticky interrupt status. It sits in the pulpemu pad frame, between the SoC pad-control signals and the board pins, and replaces per-pad functional wrappers wherever inputs feed logic or interrupts.

## Interface
- N_PADS, 8, number of pad channels (1..32)
- FILT_W, 8, glitch-filter counter/threshold width (1..16)
- PULL_MASK, '0, N_PADS-bit mask; channel k gets a static PULLUP/PULLDOWN primitive when bit k=1
- PULL_UP, '0, N_PADS-bit; for masked channels 1=PULLUP, 0=PULLDOWN

Ports:
- clk_i  in  1  bank clock
- rst_ni  in  1  reset, asynchronous, active-low
- pad_oen_i  in  N_PADS  per-pad output enable, active-low (1 = input/tristate)
- pad_out_i  in  N_PADS  value driven when pad_oen_i[k]=0
- pad_in_raw_o  out  N_PADS  unsynchronised IOBUF O (combinational)
- pad_in_o  out  N_PADS  synchronised, filtered input (registered)
- filt_en_i  in  N_PADS  per-channel filter enable
- filt_thr_i  in  FILT_W  shared filter threshold, in cycles
- evt_rise_o  out  N_PADS  one-cycle pulse on pad_in_o 0->1
- evt_fall_o  out  N_PADS  one-cycle pulse on pad_in_o 1->0
- irq_rise_en_i  in  N_PADS  rise event sets status
- irq_fall_en_i  in  N_PADS  fall event sets status
- irq_clr_i  in  N_PADS  write-1-to-clear status pulse
- irq_status_o  out  N_PADS  sticky status (registered)
- irq_o  out  1  OR of irq_status_o
- pad_io  inout  N_PADS  board pins

## Operation
- Pad: IOBUF per channel, T=pad_oen_i[k], I=pad_out_i[k], O=pad_in_raw_o[k]. Input path always samples the pin, including loopback while driving.
- Sync: 2 flops per channel, reset 0; output is sync[k].
- Filter (channel state: cnt[k], FILT_W bits):
  - filt_en_i[k]=0: pad_in_o[k] <= sync[k] each cycle; cnt <= 0.
  - filt_en_i[k]=1, sync[k]==pad_in_o[k]: cnt <= 0.
  - filt_en_i[k]=1, sync[k]!=pad_in_o[k], cnt >= filt_thr_i: pad_in_o[k] <= sync[k], cnt <= 0.
  - otherwise cnt <= cnt+1. cnt never exceeds 2^FILT_W-1 and never wraps.
  - The >= compare makes a lowered filt_thr_i mid-count accept on the next cycle. thr=0 behaves as bypass.
- Events: evt_rise_o/evt_fall_o are registered and assert in the same cycle pad_in_o takes its new value, for exactly one cycle.
- Warm-up: a 2-bit counter after reset deassertion masks events (and so status) for the first 3 cycles. pad_in_o still tracks sync, so a pin held high at reset produces no spurious rise.
- Status: status[k] <= (status[k] & ~irq_clr_i[k]) | (evt_rise&irq_rise_en | evt_fall&irq_fall_en)[k]. Set wins over a simultaneous clear. Enables gate setting only; lowering an enable does not clear status.
- irq_o = |irq_status_o, combinational from the status registers.
- Reset (async, any time, including mid-filter): sync, pad_in_o, cnt, evt_*, irq_status_o, irq_o, warm-up counter all 0. pad_oen_i/pad_out_i act directly on the IOBUF and are unaffected by reset.

## Timing
- Pin change settles before edge E0: sync[k] changes at E1, pad_in_o at E2 (bypass). With filter enabled and the pin stable, pad_in_o changes at E2+thr.
- Glitch rejection: a pulse visible in sync for ≤ thr cycles never reaches pad_in_o.
- Event pulse coincides with the pad_in_o change. Status sets one edge later; irq_o follows in the same cycle as status.
- irq_clr_i acts at the next edge; status is 0 in the following cycle unless a new event is set at that same edge.

## Test plan
- Reset with pin k=1, bypass -> pad_in_o[k]=1 by cycle 2, evt_rise_o stays 0, irq_o=0.
- thr=4, filter on, pin high-pulse of 3 cycles -> pad_in_o unchanged, no event. Pin high for 10 cycles -> pad_in_o rises 6 edges after the pin edge, one evt_rise pulse.
- irq_rise_en=1 on ch2, rising edge -> irq_status_o=0x04, irq_o=1. irq_clr_i[2] pulse -> 0x00. Clear coincident with a new event -> stays 0x04.
- thr=200 mid-count at cnt=50, drop thr to 10 -> accept on the next edge, cnt=0.
- pad_oen_i=0, pad_out_i toggling -> pin follows, loopback pad_in_o follows 2 cycles later, events fire each toggle.
- rst_ni asserted mid-filter (cnt=3) -> all outputs 0 immediately. After release, the 3-cycle warm-up suppresses events.
